frame_buffer_pingpong: RTL and testbench
========================================

FRAME_BUFFER_PINGPONG -- requirements
Module: frame_buffer_pingpong

Interface
REQ-001 SHALL have parameter DATA_W, default 16, pixel word width in bits.
REQ-002 SHALL have parameter FRAME_W, default 320, pixels per line.
REQ-003 SHALL have parameter FRAME_H, default 240, lines per frame; ADDR_W = clog2(FRAME_W*FRAME_H).
REQ-004 SHALL have port clock  input  1  single clock for all logic; there is one clock only.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port wr_valid  input  1  write pixel strobe.
REQ-007 SHALL have port wr_sof  input  1  qualified by wr_valid; marks the first pixel of a frame.
REQ-008 SHALL have port wr_data  input  DATA_W  pixel data.
REQ-009 SHALL have port rd_en  input  1  read request.
REQ-010 SHALL have port rd_addr  input  ADDR_W  linear read address, y*FRAME_W+x.
REQ-011 SHALL have port rd_vsync  input  1  one-cycle pulse at the display frame boundary; swap opportunity.
REQ-012 SHALL have port rd_data  output  DATA_W  read pixel.
REQ-013 SHALL have port rd_valid  output  1  rd_data is valid.
REQ-014 SHALL have port frame_ready  output  1  a completed frame is pending a swap.
REQ-015 SHALL have port drop_count  output  8  saturating count of frames lost.

Function
REQ-016 SHALL contain two banks of FRAME_W*FRAME_H words: wr_bank receives writes and rd_bank serves reads; they are always different banks.
REQ-017 Write counter wr_ptr SHALL take these actions:
- wr_valid&wr_sof: write to address 0 and set wr_ptr=1.
- wr_valid without wr_sof: write to wr_ptr and increment it.
REQ-018 Writer states SHALL be IDLE, FILL and DONE:
- IDLE->FILL on a sof pixel.
- FILL->DONE when the pixel at address FRAME_W*FRAME_H-1 is written.
- DONE->FILL on a sof pixel.
REQ-019 In IDLE or DONE, wr_valid pixels without wr_sof SHALL be discarded (no memory write, wr_ptr unchanged).
REQ-020 A sof pixel arriving in FILL before the last address SHALL restart the frame at address 0 and increment drop_count; the partial frame is discarded.
REQ-021 Completing a frame SHALL set frame_ready on the cycle after the last-pixel write.
REQ-022 Completing a frame while frame_ready is already 1 SHALL increment drop_count; the new frame overwrites the pending frame in the same wr_bank.
REQ-023 rd_vsync with frame_ready=1 SHALL, on the next clock, exchange wr_bank and rd_bank and clear frame_ready; rd_vsync with frame_ready=0 SHALL have no effect.
REQ-024 If rd_vsync and last-pixel completion occur in the same cycle, the swap SHALL occur on the following rd_vsync; frame_ready sets normally.
REQ-025 A sof pixel in the cycle of a swap SHALL be written to address 0 of the new wr_bank.
REQ-026 Read latency SHALL be exactly 1 cycle:
- rd_valid=1 in the cycle after rd_en=1.
- rd_data = rd_bank[rd_addr] as sampled with rd_en.
REQ-027 A read in the same cycle as a swap SHALL use the pre-swap rd_bank.
REQ-028 rd_data SHALL hold its last value when rd_valid=0.
REQ-029 rd_addr >= FRAME_W*FRAME_H SHALL return all-zero data with rd_valid=1.
REQ-030 drop_count SHALL saturate at 255 and never wrap.
REQ-031 Memory contents SHALL be undefined after power-up and SHALL NOT be cleared by reset.

Reset
REQ-032 reset SHALL asynchronously set:
- writer state IDLE, wr_ptr=0.
- wr_bank=0, rd_bank=1.
- frame_ready=0, drop_count=0.
- rd_valid=0, rd_data=0.
REQ-033 Reset asserted mid-frame SHALL abandon that frame without counting a drop; the first sof pixel after reset release starts a new frame.

Structure
REQ-034 Package fb_pkg SHALL hold the writer-state enum (IDLE/FILL/DONE), the bank-select type and the drop-counter width constant.
REQ-035 Each bank SHALL be an instance of the sub-module fb_sdp_ram, parametrised by DATA_W and depth:
- single clock, one write port, one registered read port.
- 1-cycle read latency.
- no reset on storage.

Verification (FRAME_W=4, FRAME_H=2 unless stated)
REQ-036 Write frame 0x10..0x17 starting with sof, pulse rd_vsync, read addresses 0..7 -> rd_data 0x10..0x17, each valid 1 cycle after rd_en; frame_ready 1 then 0.
REQ-037 Write two full frames (A then B) with no rd_vsync between them, then pulse rd_vsync -> reads return frame B; drop_count=1.
REQ-038 sof after 5 pixels, then a full frame C -> drop_count=1; after rd_vsync reads return only frame C.
REQ-039 rd_vsync in the same cycle as the last pixel -> no swap that cycle, frame_ready=1; next rd_vsync swaps.
REQ-040 reset asserted mid-frame, 10 non-sof pixels, then a full frame with sof -> frame_ready only after the full frame; drop_count=0.
REQ-041 Force 300 drops -> drop_count=255; read rd_addr=8 -> rd_data=0 with rd_valid=1.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types for the ping-pong frame buffer: writer FSM states, bank select
// and the drop counter width with its saturating increment.
package fb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } wr_state_t;

   typedef logic bank_sel_t;

   localparam int DROP_W = 8;

   // Increment that sticks at all-ones instead of wrapping
   function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/fb_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, single clock.
// Storage is never reset; the read register only updates on i_re so the last
// read word is held between reads.
module fb_sdp_ram #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 64,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic              i_re,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   // Write port plus read-before-write registered read port
   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      if (i_re) o_rdata <= r_mem[i_raddr];
   end

endmodule

// File: rtl/frame_buffer_pingpong.sv
// Ping-pong frame buffer. The writer fills wr_bank with a frame that starts on
// a sof pixel; a completed frame raises frame_ready and is handed to the reader
// by swapping banks on the next rd_vsync. Lost frames are counted.
module frame_buffer_pingpong
   import fb_pkg::*;
#(
   parameter  int DATA_W  = 16,
   parameter  int FRAME_W = 320,
   parameter  int FRAME_H = 240,
   localparam int DEPTH   = FRAME_W * FRAME_H,
   localparam int ADDR_W  = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              wr_valid,
   input  logic              wr_sof,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic              rd_vsync,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              frame_ready,
   output logic [DROP_W-1:0] drop_count
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   wr_state_t         r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_wr_ptr;
   bank_sel_t         r_wr_bank;
   logic              r_frame_ready;
   logic [DROP_W-1:0] r_drop_count;
   logic              r_rd_valid;
   logic              r_rd_zero;
   bank_sel_t         r_rd_sel;

   logic              w_sof, w_pix, w_we, w_last, w_drop, w_swap, w_rd_inrange;
   logic [ADDR_W-1:0] w_waddr;
   bank_sel_t         w_wsel;
   logic [DATA_W-1:0] w_q [2];

   assign w_sof = wr_valid & wr_sof;
   assign w_pix = wr_valid & ~wr_sof;

   // A completion in the vsync cycle defers the swap to the next vsync
   assign w_swap = rd_vsync & r_frame_ready & ~w_last;

   // Writes in a swap cycle already target the bank that becomes wr_bank
   assign w_wsel = r_wr_bank ^ w_swap;

   assign w_rd_inrange = ({1'b0, rd_addr} < (ADDR_W + 1)'(DEPTH));

   // Writer state register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // Writer next state: sof always (re)starts a frame, last pixel ends it
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE, DONE: if (w_sof) w_state_nxt = FILL;
         FILL:       if (w_last) w_state_nxt = DONE;
         default:    w_state_nxt = IDLE;
      endcase
   end

   // Writer outputs: memory write, frame completion and drop events
   always_comb begin
      w_we    = 1'b0;
      w_waddr = r_wr_ptr;
      w_last  = 1'b0;
      w_drop  = 1'b0;
      if (w_sof) begin
         w_we    = 1'b1;
         w_waddr = '0;
         w_drop  = (r_state == FILL);
      end else if (w_pix && r_state == FILL) begin
         w_we   = 1'b1;
         w_last = (r_wr_ptr == LAST);
         w_drop = w_last & r_frame_ready;
      end
   end

   // Write pointer: 1 after a sof pixel, advances on each accepted pixel
   always_ff @(posedge clock or posedge reset) begin
      if (reset)       r_wr_ptr <= '0;
      else if (w_sof)  r_wr_ptr <= ADDR_W'(1);
      else if (w_we)   r_wr_ptr <= w_last ? '0 : r_wr_ptr + 1'b1;
   end

   // Bank ownership, pending-frame flag and drop counter
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wr_bank     <= 1'b0;
         r_frame_ready <= 1'b0;
         r_drop_count  <= '0;
      end else begin
         if (w_swap) r_wr_bank <= ~r_wr_bank;
         if (w_last)      r_frame_ready <= 1'b1;
         else if (w_swap) r_frame_ready <= 1'b0;
         if (w_drop) r_drop_count <= sat_inc(r_drop_count);
      end
   end

   // Read side: remember which bank answered and whether the address was valid
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_rd_valid <= 1'b0;
         r_rd_zero  <= 1'b1;
         r_rd_sel   <= 1'b1;
      end else begin
         r_rd_valid <= rd_en;
         if (rd_en) begin
            r_rd_zero <= ~w_rd_inrange;
            r_rd_sel  <= ~r_wr_bank;
         end
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      fb_sdp_ram #(
         .DATA_W (DATA_W),
         .DEPTH  (DEPTH),
         .ADDR_W (ADDR_W)
      ) u_ram (
         .i_clk   (clock),
         .i_we    (w_we & (w_wsel == bank_sel_t'(b))),
         .i_waddr (w_waddr),
         .i_wdata (wr_data),
         .i_re    (rd_en & w_rd_inrange & (r_wr_bank != bank_sel_t'(b))),
         .i_raddr (rd_addr),
         .o_rdata (w_q[b])
      );
   end

   assign rd_data     = r_rd_zero ? '0 : w_q[r_rd_sel];
   assign rd_valid    = r_rd_valid;
   assign frame_ready = r_frame_ready;
   assign drop_count  = r_drop_count;

endmodule

// File: tb/tb_frame_buffer_pingpong.sv
// Randomised and directed bench for frame_buffer_pingpong with a scoreboard.
// A second instance with a 3x2 frame exercises out-of-range reads.
module tb_frame_buffer_pingpong;

   localparam int DW = 16;
   localparam int D  = 8;
   localparam int AW = 3;

   logic          clock = 1'b0;
   logic          reset;
   logic          wr_valid, wr_sof, rd_en, rd_vsync;
   logic [DW-1:0] wr_data;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data, rd_data2;
   logic          rd_valid, frame_ready, rd_valid2, frame_ready2;
   logic [7:0]    drop_count, drop_count2;

   always #5 clock = ~clock;

   frame_buffer_pingpong #(.DATA_W(DW), .FRAME_W(4), .FRAME_H(2)) dut (
      .clock(clock), .reset(reset), .wr_valid(wr_valid), .wr_sof(wr_sof),
      .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_vsync(rd_vsync),
      .rd_data(rd_data), .rd_valid(rd_valid), .frame_ready(frame_ready),
      .drop_count(drop_count));

   frame_buffer_pingpong #(.DATA_W(DW), .FRAME_W(3), .FRAME_H(2)) dut2 (
      .clock(clock), .reset(reset), .wr_valid(wr_valid), .wr_sof(wr_sof),
      .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_vsync(rd_vsync),
      .rd_data(rd_data2), .rd_valid(rd_valid2), .frame_ready(frame_ready2),
      .drop_count(drop_count2));

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct { bit chk; logic [DW-1:0] data; } exp_t;
   exp_t q[$], q2[$];

   logic [DW-1:0] m_mem [2][D];
   bit            m_known [2][D];
   int            m_wb, m_drops, m_pos, m_rb, m_tgt;
   bit            m_ready, m_fill, m_comp, m_swap;

   always @(posedge clock) begin
      if (reset) begin
         m_wb = 0; m_ready = 0; m_drops = 0; m_fill = 0; m_pos = 0;
         q.delete(); q2.delete();
      end else begin
         m_rb = 1 - m_wb;
         if (rd_en) begin
            q.push_back('{m_known[m_rb][rd_addr], m_mem[m_rb][rd_addr]});
            q2.push_back('{(int'(rd_addr) >= 6), '0});
         end
         m_comp = wr_valid && !wr_sof && m_fill && (m_pos == D - 1);
         m_swap = rd_vsync && m_ready && !m_comp;
         m_tgt  = m_swap ? m_rb : m_wb;
         if (wr_valid && wr_sof) begin
            if (m_fill && m_drops < 255) m_drops++;
            m_mem[m_tgt][0] = wr_data; m_known[m_tgt][0] = 1;
            m_pos = 1; m_fill = 1;
         end else if (wr_valid && m_fill) begin
            m_mem[m_tgt][m_pos] = wr_data; m_known[m_tgt][m_pos] = 1;
            if (m_comp) begin
               m_fill = 0;
               if (m_ready && m_drops < 255) m_drops++;
            end else m_pos++;
         end
         if (m_comp) m_ready = 1;
         else if (m_swap) m_ready = 0;
         if (m_swap) m_wb = m_rb;
      end
   end

   // ---------------- monitors ----------------
   logic [DW-1:0] last_rd = '0;
   exp_t          e1, e2;

   always @(negedge clock) begin
      if (reset) last_rd = '0;
      else if (rd_valid) begin
         if (q.size() == 0) chk("rd_valid_unexpected", 1, 0);
         else begin
            e1 = q.pop_front();
            if (e1.chk) chk("rd_data", rd_data, e1.data);
            last_rd = e1.chk ? e1.data : rd_data;
         end
      end else begin
         if (q.size() != 0) begin
            chk("rd_latency", 0, 1);
            void'(q.pop_front());
         end
         chk("rd_hold", rd_data, last_rd);
      end
   end

   always @(negedge clock) begin
      if (!reset && rd_valid2) begin
         if (q2.size() == 0) chk("rd2_valid_unexpected", 1, 0);
         else begin
            e2 = q2.pop_front();
            if (e2.chk) chk("rd_oor_zero", rd_data2, 0);
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic drv(input bit v, input bit s, input logic [DW-1:0] d,
                      input bit vs, input bit re, input logic [AW-1:0] a);
      @(negedge clock); #1;
      wr_valid = v; wr_sof = s; wr_data = d; rd_vsync = vs; rd_en = re; rd_addr = a;
   endtask

   task automatic idle();
      drv(0, 0, '0, 0, 0, '0);
   endtask

   task automatic wframe(input logic [DW-1:0] base);
      for (int i = 0; i < D; i++) drv(1, i == 0, base + DW'(i), 0, 0, '0);
   endtask

   task automatic rframe();
      for (int i = 0; i < D; i++) drv(0, 0, '0, 0, 1, AW'(i));
   endtask

   task automatic vsync();
      drv(0, 0, '0, 1, 0, '0);
   endtask

   task automatic do_reset();
      @(negedge clock); #1;
      reset = 1;
      wr_valid = 0; wr_sof = 0; wr_data = '0; rd_vsync = 0; rd_en = 0; rd_addr = '0;
      @(negedge clock); #1;
      reset = 0;
   endtask

   task automatic model_chk(input string tag);
      chk({tag, "_frame_ready"}, frame_ready, m_ready);
      chk({tag, "_drop_count"}, drop_count, m_drops);
   endtask

   initial begin
      reset = 1;
      wr_valid = 0; wr_sof = 0; wr_data = '0; rd_vsync = 0; rd_en = 0; rd_addr = '0;
      repeat (2) @(negedge clock);
      #1 reset = 0;
      idle();
      chk("reset_frame_ready", frame_ready, 0);
      chk("reset_drop_count", drop_count, 0);
      chk("reset_rd_valid", rd_valid, 0);
      chk("reset_rd_data", rd_data, 0);

      // basic frame, swap, readback
      wframe(16'h10); idle();
      chk("t36_ready_set", frame_ready, 1);
      vsync(); idle();
      chk("t36_ready_clr", frame_ready, 0);
      rframe(); idle(); idle();

      // two frames without vsync: B overwrites A, one drop
      do_reset();
      wframe(16'h20); wframe(16'h30); idle();
      chk("t37_drop", drop_count, 1);
      vsync(); rframe(); idle(); idle();

      // restart after 5 pixels, then full frame C
      do_reset();
      for (int i = 0; i < 5; i++) drv(1, i == 0, 16'h40 + DW'(i), 0, 0, '0);
      wframe(16'h50); idle();
      chk("t38_drop", drop_count, 1);
      vsync(); rframe(); idle(); idle();

      // vsync together with last pixel: no swap yet, reads still return C
      for (int i = 0; i < D - 1; i++) drv(1, i == 0, 16'h60 + DW'(i), 0, 0, '0);
      drv(1, 0, 16'h67, 1, 0, '0); idle();
      chk("t39_ready", frame_ready, 1);
      rframe(); vsync(); idle();
      chk("t39_swapped", frame_ready, 0);
      rframe(); idle(); idle();

      // reset mid-frame, stray pixels ignored, no drop counted
      do_reset();
      for (int i = 0; i < 3; i++) drv(1, i == 0, 16'h70 + DW'(i), 0, 0, '0);
      do_reset();
      for (int i = 0; i < 10; i++) drv(1, 0, 16'h80 + DW'(i), 0, 0, '0);
      idle();
      chk("t40_not_ready", frame_ready, 0);
      wframe(16'h90); idle();
      chk("t40_ready", frame_ready, 1);
      chk("t40_drop", drop_count, 0);
      vsync(); rframe(); idle(); idle();

      // drop saturation and out-of-range reads on the 3x2 instance
      do_reset();
      for (int i = 0; i < 301; i++) drv(1, 1, DW'(i), 0, 0, '0);
      idle();
      chk("t41_drop_sat", drop_count, 255);
      rframe(); idle(); idle();

      // randomised traffic against the model
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         automatic bit v = ($urandom_range(0, 3) != 0);
         drv(v, v && ($urandom_range(0, 19) == 0), DW'($urandom),
             ($urandom_range(0, 9) == 0), $urandom_range(0, 1) == 1,
             AW'($urandom_range(0, D - 1)));
         if (n % 100 == 99) model_chk("rand");
      end
      idle(); idle(); idle();
      model_chk("final");
      chk("queue_drained", q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
